param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file: configurable data width, depth and read-port count.
- Adds an optional hardwired zero register and a hardware clear sequencer that zeroes every entry after reset or on request.
- Adds a dropped-write indicator.
- Sits in the microprocessor datapath between instruction decode (addresses) and the ALU/writeback stage.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 32, number of entries (need not be a power of two).
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH.
- NUM_READ, 2, number of asynchronous read ports (1..4).
- ZERO_REG, 1, if 1 entry 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- readRegister  input  NUM_READ*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- readData  output  NUM_READ*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
- writeRegister  input  ADDR_W  write address.
- writeData  input  DATA_W  write data.
- regWrite  input  1  write enable, sampled on rising clk.
- clearReq  input  1  request a full clear sequence.
- busy  output  1  high while the clear sequence runs.
- writeDrop  output  1  one-cycle pulse: previous-cycle write was discarded because busy.

Behaviour:
- Reset: single clock, synchronous, active-low. rst_n sampled low at a rising clk edge sets state CLEAR, clearCnt=0 and writeDrop=0.
  - busy is combinational (state==CLEAR), so it reads 1 from the first reset edge onward.
  - While rst_n stays low, clearCnt holds at 0.
- FSM states: CLEAR, READY.
  - CLEAR: each edge with rst_n=1 writes 0 to entry clearCnt, then clearCnt++. At the edge where clearCnt==DEPTH-1 the entry is zeroed and state goes to READY. The clear takes exactly DEPTH cycles after rst_n release.
  - READY: clearReq=1 at an edge sets state CLEAR and clearCnt=0. clearReq is ignored while in CLEAR (no restart).
  - Reset mid-clear restarts the sequence from 0.
- Write (READY only): on an edge with regWrite=1, mem[writeRegister] <= writeData.
  - Address >= DEPTH: write ignored.
  - Address 0 with ZERO_REG=1: write ignored.
  - Neither ignored case sets writeDrop.
- Write during CLEAR (regWrite=1 with busy=1): write discarded; writeDrop=1 on the following cycle only.
- Write coinciding with clearReq in READY: the write commits first, then CLEAR starts (the entry is later zeroed).
- Read: combinational, zero latency.
  - readData port k = mem[readRegister k].
  - Returns 0 if the address >= DEPTH, if address 0 with ZERO_REG=1, or whenever busy=1.
  - All ports are independent; any ports may share an address.
- Reset value of memory contents: undefined until the clear completes; busy masks reads meanwhile.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: write-through forwarding. In READY, when regWrite=1 and readRegister k == writeRegister (a valid, non-zero-register address), readData port k = writeData in the same cycle.
- Undefined: the read returns the old stored value until after the edge. This matches the original register-file behaviour.

Decomposition:
- Shared package rf_pkg holds:
  - the state enum (RF_CLEAR, RF_READY);
  - a default-width constant set (RF_DATA_W=32, RF_DEPTH=32, RF_ADDR_W=5);
  - a function computing addr-valid (addr < DEPTH and not the zero register).
- One sub-module, rf_clear_seq: the FSM plus clearCnt. It outputs busy, clrWe and clrAddr.
- Storage, read muxes and bypass stay in the top module.

Test Plan:
- Reset then release: busy=1 for exactly 32 cycles; all readData=0 during that time. After busy falls, reading every entry returns 0.
- Write i to entry i for i=1..31; then read port0=i, port1=31-i for all i. Expect readData0=i, readData1=31-i; entry 0 reads 0 (ZERO_REG=1) after writing 32'hFF to address 0.
- During clear, regWrite=1, addr 7, data 32'hAB: writeDrop pulses one cycle later. After clear, entry 7 reads 0.
- Write 32'h1234 to entry 5, then pulse clearReq with simultaneous write 32'h55 to entry 6: busy=1 for 32 cycles; entries 5 and 6 read 0 afterward.
- DEPTH=20, NUM_READ=3: write to address 25 is ignored; reading address 25 returns 0; three ports reading address 3 all return the same value.
- With RF_BYPASS_EN: write 32'hDEAD to 9 while port0 reads 9 -> readData0=32'hDEAD before the edge. Without the macro, the pre-edge value is the old data.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file:
//   - rf_state_e    : clear-sequencer states (RF_CLEAR, RF_READY)
//   - RF_DATA_W, RF_DEPTH, RF_ADDR_W : default geometry (32 x 32, 5-bit address)
//   - rf_addr_valid : true when an address names a real, writable entry
// No ports (package).
// ---------------------------------------------------------------------------
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

  // An address is usable for storage only if it lies inside the array and
  // is not the hardwired zero register.
  function automatic logic rf_addr_valid(input logic [31:0] addr,
                                         input int unsigned depth,
                                         input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/param_register_file_if.sv
// ---------------------------------------------------------------------------
// param_register_file_if
// Bus between decode/writeback and the register file.
//   readRegister  : NUM_READ packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   readData      : NUM_READ packed read words,     port k at [k*DATA_W +: DATA_W]
//   writeRegister : write address
//   writeData     : write word
//   regWrite      : write enable
//   clearReq      : request a full clear sequence
//   busy          : clear sequence running
//   writeDrop     : one-cycle pulse, previous write was discarded while busy
// Modports: master (datapath side), slave (register file side).
// ---------------------------------------------------------------------------
interface param_register_file_if
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = 2
);

  logic [NUM_READ*ADDR_W-1:0] readRegister;
  logic [NUM_READ*DATA_W-1:0] readData;
  logic [ADDR_W-1:0]          writeRegister;
  logic [DATA_W-1:0]          writeData;
  logic                       regWrite;
  logic                       clearReq;
  logic                       busy;
  logic                       writeDrop;

  modport master (
    output readRegister, writeRegister, writeData, regWrite, clearReq,
    input  readData, busy, writeDrop
  );

  modport slave (
    input  readRegister, writeRegister, writeData, regWrite, clearReq,
    output readData, busy, writeDrop
  );

endinterface

// File: rtl/rf_clear_seq.sv
// ---------------------------------------------------------------------------
// rf_clear_seq
// Clear sequencer: after reset or on request, walks clr_addr from 0 to
// DEPTH-1, one entry per clock, then returns to READY.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_req  : start a clear (honoured in READY only)
//   busy       : high while in CLEAR
//   clr_we     : zero the entry at clr_addr this cycle
//   clr_addr   : entry being cleared
// ---------------------------------------------------------------------------
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // A new clearReq arriving while already clearing is ignored, so the walk
  // always completes in exactly DEPTH cycles once started.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = clr_cnt_q;
    unique case (state_q)
      RF_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = RF_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_d   = RF_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// param_register_file
// Parametrised multi-read, single-write register file with optional
// hardwired zero register, hardware clear sequencer and dropped-write flag.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (starts a clear)
//   bus   : param_register_file_if.slave (reads, write, clearReq, busy,
//           writeDrop)
// Optional build macro RF_BYPASS_EN: forwards writeData to any read port
// addressing the entry being written in the same cycle.
// ---------------------------------------------------------------------------
module param_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  param_register_file_if.slave bus
);

  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic                       busy;
  logic                       clr_we;
  logic [ADDR_W-1:0]          clr_addr;
  logic                       wr_en_d;
  logic [ADDR_W-1:0]          wr_addr_d;
  logic [DATA_W-1:0]          wr_data_d;
  logic                       write_drop_q, write_drop_d;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_word;
  logic [NUM_READ*DATA_W-1:0] read_data;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_req(bus.clearReq),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Clearing owns the write port; user writes only land in READY and only
  // to real, non-zero-register entries.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = clr_addr;
    wr_data_d    = '0;
    write_drop_d = bus.regWrite && busy;
    if (clr_we) begin
      wr_en_d = 1'b1;
    end else if (bus.regWrite &&
                 rf_addr_valid(32'(bus.writeRegister), DEPTH, ZERO_REG != 0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.writeRegister;
      wr_data_d = bus.writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_drop_q <= 1'b0;
    end else begin
      write_drop_q <= write_drop_d;
    end
  end

  // Reads are masked to zero while busy, which also hides the undefined
  // contents left behind by reset until the clear walk has finished.
  always_comb begin
    read_data = '0;
    rd_addr   = '0;
    rd_word   = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_addr = bus.readRegister[k*ADDR_W +: ADDR_W];
      rd_word = '0;
      if (!busy && rf_addr_valid(32'(rd_addr), DEPTH, ZERO_REG != 0)) begin
        rd_word = mem_q[rd_addr];
`ifdef RF_BYPASS_EN
        if (bus.regWrite && (rd_addr == bus.writeRegister)) begin
          rd_word = bus.writeData;
        end
`endif
      end
      read_data[k*DATA_W +: DATA_W] = rd_word;
    end
  end

  assign bus.readData  = read_data;
  assign bus.busy      = busy;
  assign bus.writeDrop = write_drop_q;

endmodule

// File: tb/tb_param_register_file.sv
// ---------------------------------------------------------------------------
// tb_param_register_file
// Self-checking bench for param_register_file. DUT A uses the default
// 32 x 32, two read ports, zero register; DUT B uses DEPTH=20, three read
// ports. Expected read words come from a small memory model per DUT and are
// queued when addresses are driven, then popped against readData.
// ---------------------------------------------------------------------------
module tb_param_register_file;

  logic clk;
  logic rst_n;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] memA [32];
  logic [31:0] memB [20];
  logic [31:0] expQ [$];

  param_register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) ifA ();
  param_register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(3)) ifB ();

  param_register_file #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1)
  ) dutA (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifA)
  );

  param_register_file #(
    .DATA_W(32), .DEPTH(20), .ADDR_W(5), .NUM_READ(3), .ZERO_REG(1)
  ) dutB (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelReadA(input int addr);
    return (addr > 0 && addr < 32) ? memA[addr] : 32'd0;
  endfunction

  function automatic logic [31:0] modelReadB(input int addr);
    return (addr > 0 && addr < 20) ? memB[addr] : 32'd0;
  endfunction

  task automatic popCheck(input string tag, input logic [31:0] actual);
    logic [31:0] exp;
    if (expQ.size() == 0) begin
      checkOutput({tag, " scoreboard-empty"}, 32'd1, 32'd0);
    end else begin
      exp = expQ.pop_front();
      checkOutput(tag, actual, exp);
    end
  endtask

  // Drives DUT A read addresses at a falling edge and checks both ports.
  task automatic applyStimulus(input string tag, input int a0, input int a1,
                               input bit masked);
    @(negedge clk);
    ifA.readRegister = {5'(a1), 5'(a0)};
    expQ.push_back(masked ? 32'd0 : modelReadA(a0));
    expQ.push_back(masked ? 32'd0 : modelReadA(a1));
    #1;
    popCheck({tag, ".p0"}, ifA.readData[31:0]);
    popCheck({tag, ".p1"}, ifA.readData[63:32]);
  endtask

  task automatic applyStimulusB(input string tag, input int a0, input int a1,
                                input int a2);
    @(negedge clk);
    ifB.readRegister = {5'(a2), 5'(a1), 5'(a0)};
    expQ.push_back(modelReadB(a0));
    expQ.push_back(modelReadB(a1));
    expQ.push_back(modelReadB(a2));
    #1;
    popCheck({tag, ".p0"}, ifB.readData[31:0]);
    popCheck({tag, ".p1"}, ifB.readData[63:32]);
    popCheck({tag, ".p2"}, ifB.readData[95:64]);
  endtask

  task automatic writeA(input int addr, input logic [31:0] data);
    @(negedge clk);
    ifA.regWrite      = 1'b1;
    ifA.writeRegister = 5'(addr);
    ifA.writeData     = data;
    @(negedge clk);
    ifA.regWrite = 1'b0;
    if (addr > 0 && addr < 32) memA[addr] = data;
  endtask

  task automatic writeB(input int addr, input logic [31:0] data);
    @(negedge clk);
    ifB.regWrite      = 1'b1;
    ifB.writeRegister = 5'(addr);
    ifB.writeData     = data;
    @(negedge clk);
    ifB.regWrite = 1'b0;
    if (addr > 0 && addr < 20) memB[addr] = data;
  endtask

  initial begin
    int n;
    logic [31:0] preEdge;

    for (int i = 0; i < 32; i++) memA[i] = 32'd0;
    for (int i = 0; i < 20; i++) memB[i] = 32'd0;
    rst_n = 1'b0;
    ifA.readRegister = '0; ifA.writeRegister = '0; ifA.writeData = '0;
    ifA.regWrite = 1'b0;   ifA.clearReq = 1'b0;
    ifB.readRegister = '0; ifB.writeRegister = '0; ifB.writeData = '0;
    ifB.regWrite = 1'b0;   ifB.clearReq = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", 32'(ifA.busy), 32'd1);
    checkOutput("resetDrop", 32'(ifA.writeDrop), 32'd0);
    applyStimulus("resetRead", 0, 5, 1'b1);

    // Release reset and time the clear; a write attempted mid-clear is dropped
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (ifA.busy === 1'b1 && n < 100) begin
      ifA.readRegister = {5'd31, 5'd7};
      expQ.push_back(32'd0);
      expQ.push_back(32'd0);
      #1;
      popCheck("clearMask.p0", ifA.readData[31:0]);
      popCheck("clearMask.p1", ifA.readData[63:32]);
      if (n == 5) begin
        ifA.regWrite      = 1'b1;
        ifA.writeRegister = 5'd7;
        ifA.writeData     = 32'hAB;
      end
      if (n == 6) begin
        checkOutput("dropPulse", 32'(ifA.writeDrop), 32'd1);
        ifA.regWrite = 1'b0;
      end
      if (n == 7) checkOutput("dropOneCycle", 32'(ifA.writeDrop), 32'd0);
      @(negedge clk);
      n++;
    end
    checkOutput("resetClearCycles", 32'(n), 32'd32);
    checkOutput("busyBAfterClear", 32'(ifB.busy), 32'd0);

    for (int i = 0; i < 32; i++) applyStimulus("cleared", i, 31 - i, 1'b0);
    applyStimulus("entry7AfterDrop", 7, 7, 1'b0);

    // Zero register ignores writes without flagging a drop
    writeA(0, 32'hFF);
    checkOutput("zeroRegNoDrop", 32'(ifA.writeDrop), 32'd0);
    for (int i = 1; i < 32; i++) writeA(i, 32'(i));
    for (int i = 0; i < 32; i++) applyStimulus("readback", i, 31 - i, 1'b0);

    // clearReq together with a write: write lands, then everything is zeroed
    writeA(5, 32'h1234);
    applyStimulus("preClear", 5, 6, 1'b0);
    @(negedge clk);
    ifA.clearReq      = 1'b1;
    ifA.regWrite      = 1'b1;
    ifA.writeRegister = 5'd6;
    ifA.writeData     = 32'h55;
    @(negedge clk);
    ifA.clearReq = 1'b0;
    ifA.regWrite = 1'b0;
    checkOutput("clearReqBusy", 32'(ifA.busy), 32'd1);
    checkOutput("clearReqNoDrop", 32'(ifA.writeDrop), 32'd0);
    for (int i = 0; i < 32; i++) memA[i] = 32'd0;
    n = 0;
    while (ifA.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqClearCycles", 32'(n), 32'd32);
    applyStimulus("postClear", 5, 6, 1'b0);
    applyStimulus("postClearMix", 31, 1, 1'b0);

    // Same-cycle read of the entry being written
    writeA(9, 32'h1111);
    @(negedge clk);
    ifA.regWrite      = 1'b1;
    ifA.writeRegister = 5'd9;
    ifA.writeData     = 32'hDEAD;
    ifA.readRegister  = {5'd0, 5'd9};
`ifdef RF_BYPASS_EN
    preEdge = 32'hDEAD;
`else
    preEdge = memA[9];
`endif
    expQ.push_back(preEdge);
    expQ.push_back(32'd0);
    #1;
    popCheck("bypass.p0", ifA.readData[31:0]);
    popCheck("bypass.p1", ifA.readData[63:32]);
    @(negedge clk);
    ifA.regWrite = 1'b0;
    memA[9] = 32'hDEAD;
    applyStimulus("postEdge9", 9, 0, 1'b0);

    // DEPTH=20, three ports: out-of-range write ignored, shared address
    writeB(3, 32'hC0FFEE);
    writeB(25, 32'hBAD);
    checkOutput("oobNoDrop", 32'(ifB.writeDrop), 32'd0);
    writeB(19, 32'h1919);
    applyStimulusB("shared3", 3, 3, 3);
    applyStimulusB("oobRead", 25, 19, 3);
    applyStimulusB("zeroB", 0, 20, 19);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
